sram_arbiter_2x1: RTL and testbench
===================================

Name: sram_arbiter_2x1

Overview:
- Shares the single-port data SRAM between two masters: m0 = CPU data path after address decode, m1 = secondary requester (DMA / debug loader).
- Grants at most one access per cycle, round-robin or fixed priority.
- Routes the 1-cycle-latency SRAM read data back to the master that issued the read.
- Sits between the CPU-side address decoder and the data SRAM. The SRAM-side ports carry the same signal set as the existing data_sram_* interface.

Parameters:
- FIXED_PRIO, 0: 0 = round-robin arbitration; 1 = m0 always wins ties.
- Data and address width is `XLEN from cpu.vh; not a parameter.

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high reset
- m0_req  in  1  m0 access request; held with its controls until m0_gnt
- m0_wen  in  4  m0 byte write enables; 0 = read
- m0_addr  in  `XLEN  m0 byte address
- m0_wdata  in  `XLEN  m0 write data
- m0_gnt  out  1  m0 access performed this cycle
- m0_rvalid  out  1  m0 read data valid
- m0_rdata  out  `XLEN  m0 read data
- m1_req, m1_wen, m1_addr, m1_wdata, m1_gnt, m1_rvalid, m1_rdata: same widths and meanings for m1
- data_sram_en  out  1  SRAM enable
- data_sram_wen  out  4  SRAM byte write enables
- data_sram_addr  out  `XLEN  SRAM address
- data_sram_wdata  out  `XLEN  SRAM write data
- data_sram_rdata  in  `XLEN  SRAM read data, valid 1 cycle after a read enable

Behaviour:
- Grant is combinational from the req inputs and the registered prio_r:
  - Only one req high: that master is granted.
  - Both high, FIXED_PRIO=0: the master named by prio_r is granted.
  - Both high, FIXED_PRIO=1: m0 is granted.
- m0_gnt and m1_gnt are one-hot or zero. Both are 0 while reset=1.
- prio_r (1 bit, reset value 0 = m0 favoured):
  - After any cycle with a grant, prio_r <= index of the non-granted master (m1 after an m0 grant, m0 after an m1 grant).
  - Unchanged in cycles with no grant.
  - Ignored when FIXED_PRIO=1.
- SRAM outputs:
  - data_sram_en = m0_gnt | m1_gnt.
  - data_sram_wen, data_sram_addr, data_sram_wdata are muxed from the granted master.
  - With no grant, all SRAM outputs are 0.
- A request completes in its grant cycle. The master may change req or controls in the next cycle.
- Read tracking: rd_owner_r (2 bits, one-hot, reset value 0) <= {m1_gnt & (m1_wen==0), m0_gnt & (m0_wen==0)}.
- Read response:
  - mX_rvalid = rd_owner_r[X].
  - mX_rdata = data_sram_rdata when rd_owner_r[X], else 0.
  - Read latency is exactly 1 cycle after gnt. Back-to-back reads sustain 1 per cycle.
- Writes: no response beyond gnt. Neither rvalid is asserted the cycle after a write grant.
- Read of master A followed by a grant to master B: A's rvalid and B's gnt may be high in the same cycle. Routing follows rd_owner_r only.
- Reset mid-operation:
  - The cycle after reset asserts: prio_r=0, rd_owner_r=0.
  - All gnt and rvalid outputs are 0 while reset=1.
  - A read granted in the cycle before reset asserts loses its response (rvalid stays 0).
- Outputs after reset: all gnt/rvalid/rdata = 0; data_sram_en=0, data_sram_wen=0, data_sram_addr=0, data_sram_wdata=0.
- Starvation bound: with FIXED_PRIO=0 and both masters requesting continuously, each master waits at most 1 cycle.

Decomposition:
- cpu.vh additions: `ARB_M0 = 1'b0 and `ARB_M1 = 1'b1, the prio and index encodings.
- Sub-module rr_arb2: req[1:0] + prio_r -> gnt[1:0], plus next-prio logic.
- prio_r and rd_owner_r are instantiated with sirv_gnrl_dfflr; lden=1 for rd_owner_r, lden=any grant for prio_r.

Test Plan:
1. Reset held 3 cycles with m0_req=m1_req=1 -> all gnt/rvalid=0, data_sram_en=0. First cycle after release: m0_gnt=1 (prio_r=0).
2. m0 alone reads 0x1000_0040; SRAM returns 0xDEAD_BEEF -> m0_gnt cycle N, m0_rvalid=1 and m0_rdata=0xDEAD_BEEF at N+1; m1_rvalid=0, m1_rdata=0.
3. Both masters request reads continuously for 6 cycles, FIXED_PRIO=0 -> grants alternate m0,m1,m0,m1,m0,m1. Each rvalid follows its gnt by 1 cycle with the correct data.
4. Same stimulus as 3 with FIXED_PRIO=1 -> m0_gnt=1 for all 6 cycles, m1_gnt=0. m1 is granted in the first cycle m0_req drops.
5. m1 write, wen=4'b0011, data 0x1234_5678, addr 0x40, then an m0 read of 0x40 -> data_sram_wen=4'b0011 in the write cycle; no rvalid after the write; m0_rvalid follows the read by 1 cycle.
6. m0 read granted at cycle N, reset asserted at N+1 -> m0_rvalid=0 at N+1, and prio_r=0 and rd_owner_r=0 from N+2.

Source files
------------

// File: rtl/sram_arbiter_2x1_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : sram_arbiter_2x1_pkg
//  Purpose  : Shared widths, master index encodings and the SRAM command
//             bundle used by the two-master data-SRAM arbiter.
//  Contents : XLEN        - data/address width of the CPU data path
//             ARB_M0/M1   - master index encodings (also the prio encoding)
//             sram_cmd_t  - write-enable/address/write-data bundle
//             is_read()   - classifies an access from its byte enables
//  Revision : 1.0 - initial release
// ============================================================================
package sram_arbiter_2x1_pkg;

   localparam int   XLEN   = 32;
   localparam logic ARB_M0 = 1'b0;
   localparam logic ARB_M1 = 1'b1;

   typedef struct packed {
      logic [3:0]      wen;
      logic [XLEN-1:0] addr;
      logic [XLEN-1:0] wdata;
   } sram_cmd_t;

   // An access with no byte enables set is a read.
   function automatic logic is_read(input logic [3:0] wen);
      return (wen == 4'b0000);
   endfunction

endpackage : sram_arbiter_2x1_pkg
`default_nettype wire

// File: rtl/sram_arbiter_2x1_rr_arb2.sv
`default_nettype none
// ============================================================================
//  Module   : rr_arb2
//  Purpose  : Two-requester arbiter. Grant is purely combinational from the
//             requests and the current priority; it also produces the
//             priority value to be registered for the next cycle.
//  Ports    : i_enable   - grants are forced to zero when low
//             i_req[1:0] - request per master (bit index = master index)
//             i_prio     - master favoured on a tie (round-robin mode)
//             o_gnt[1:0] - one-hot or zero grant
//             o_prio_nxt - priority for the next cycle
//  Revision : 1.0 - initial release
// ============================================================================
module rr_arb2
   import sram_arbiter_2x1_pkg::*;
#(
   parameter int FIXED_PRIO = 0
) (
   input  logic       i_enable,
   input  logic [1:0] i_req,
   input  logic       i_prio,
   output logic [1:0] o_gnt,
   output logic       o_prio_nxt
);

   logic w_tie_winner;

   // Fixed-priority mode ignores the rotating priority entirely.
   if (FIXED_PRIO != 0) begin : g_fixed
      assign w_tie_winner = ARB_M0;
   end else begin : g_rr
      assign w_tie_winner = i_prio;
   end

   always_comb begin
      o_gnt = 2'b00;
      if (i_enable) begin
         case (i_req)
            2'b01:   o_gnt = 2'b01;
            2'b10:   o_gnt = 2'b10;
            2'b11:   o_gnt = (w_tie_winner == ARB_M1) ? 2'b10 : 2'b01;
            default: o_gnt = 2'b00;
         endcase
      end
   end

   // After a grant the other master becomes favoured; idle cycles keep it.
   always_comb begin
      o_prio_nxt = i_prio;
      if (o_gnt[0]) begin
         o_prio_nxt = ARB_M1;
      end else if (o_gnt[1]) begin
         o_prio_nxt = ARB_M0;
      end
   end

endmodule : rr_arb2
`default_nettype wire

// File: rtl/sram_arbiter_2x1.sv
`default_nettype none
// ============================================================================
//  Module   : sram_arbiter_2x1
//  Purpose  : Shares the single-port data SRAM between m0 (CPU data path)
//             and m1 (DMA / debug loader). At most one access per cycle;
//             the 1-cycle-latency read data is returned to the master that
//             issued the read.
//  Ports    : clk, reset            - clock, synchronous active-high reset
//             mX_req/wen/addr/wdata - master request and controls
//             mX_gnt                - access performed this cycle
//             mX_rvalid/rdata       - read response, one cycle after gnt
//             data_sram_*           - SRAM-side enable, controls, read data
//  Revision : 1.0 - initial release
// ============================================================================
module sram_arbiter_2x1
   import sram_arbiter_2x1_pkg::*;
#(
   parameter int FIXED_PRIO = 0
) (
   input  logic            clk,
   input  logic            reset,
   input  logic            m0_req,
   input  logic [3:0]      m0_wen,
   input  logic [XLEN-1:0] m0_addr,
   input  logic [XLEN-1:0] m0_wdata,
   output logic            m0_gnt,
   output logic            m0_rvalid,
   output logic [XLEN-1:0] m0_rdata,
   input  logic            m1_req,
   input  logic [3:0]      m1_wen,
   input  logic [XLEN-1:0] m1_addr,
   input  logic [XLEN-1:0] m1_wdata,
   output logic            m1_gnt,
   output logic            m1_rvalid,
   output logic [XLEN-1:0] m1_rdata,
   output logic            data_sram_en,
   output logic [3:0]      data_sram_wen,
   output logic [XLEN-1:0] data_sram_addr,
   output logic [XLEN-1:0] data_sram_wdata,
   input  logic [XLEN-1:0] data_sram_rdata
);

   logic       prio_q;
   logic       prio_d;
   logic [1:0] rd_owner_q;
   logic [1:0] rd_owner_d;

   logic [1:0] w_gnt;
   logic       w_arb_en;
   sram_cmd_t  w_cmd;

   assign w_arb_en = ~reset;

   rr_arb2 #(
      .FIXED_PRIO (FIXED_PRIO)
   ) u_arb (
      .i_enable   (w_arb_en),
      .i_req      ({m1_req, m0_req}),
      .i_prio     (prio_q),
      .o_gnt      (w_gnt),
      .o_prio_nxt (prio_d)
   );

   assign m0_gnt = w_gnt[0];
   assign m1_gnt = w_gnt[1];

   // Controls of the granted master; all zero when nobody is granted.
   always_comb begin
      w_cmd = '0;
      if (w_gnt[0]) begin
         w_cmd = '{wen: m0_wen, addr: m0_addr, wdata: m0_wdata};
      end else if (w_gnt[1]) begin
         w_cmd = '{wen: m1_wen, addr: m1_addr, wdata: m1_wdata};
      end
   end

   assign data_sram_en    = |w_gnt;
   assign data_sram_wen   = w_cmd.wen;
   assign data_sram_addr  = w_cmd.addr;
   assign data_sram_wdata = w_cmd.wdata;

   // Remember which master (if any) owns the data coming back next cycle.
   always_comb begin
      rd_owner_d = {w_gnt[1] & is_read(m1_wen), w_gnt[0] & is_read(m0_wen)};
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         prio_q     <= ARB_M0;
         rd_owner_q <= 2'b00;
      end else begin
         prio_q     <= prio_d;
         rd_owner_q <= rd_owner_d;
      end
   end

   // A read granted just before reset loses its response, so the valids
   // are also masked while reset is high.
   assign m0_rvalid = rd_owner_q[0] & ~reset;
   assign m1_rvalid = rd_owner_q[1] & ~reset;
   assign m0_rdata  = m0_rvalid ? data_sram_rdata : '0;
   assign m1_rdata  = m1_rvalid ? data_sram_rdata : '0;

endmodule : sram_arbiter_2x1
`default_nettype wire

// File: tb/tb_sram_arbiter_2x1.sv
`default_nettype none
// ============================================================================
//  Module   : tb_sram_arbiter_2x1
//  Purpose  : Self-checking bench. Two arbiters share one stimulus stream:
//             index 0 is round-robin, index 1 is fixed priority. Each has
//             its own behavioural SRAM. Expected read data is pushed to a
//             scoreboard at grant time and compared when the response is due.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_sram_arbiter_2x1;

   logic        clk = 1'b0;
   logic        reset;
   logic        m0_req, m1_req;
   logic [3:0]  m0_wen, m1_wen;
   logic [31:0] m0_addr, m0_wdata, m1_addr, m1_wdata;

   logic [1:0]  g0_v, g1_v, rv0_v, rv1_v, en_v;
   logic [31:0] rd0_v [2];
   logic [31:0] rd1_v [2];
   logic [31:0] sa_v  [2];
   logic [31:0] swd_v [2];
   logic [31:0] srd_v [2];
   logic [3:0]  swen_v[2];

   always #5 clk = ~clk;

   sram_arbiter_2x1 #(.FIXED_PRIO(0)) u_rr (
      .clk(clk), .reset(reset),
      .m0_req(m0_req), .m0_wen(m0_wen), .m0_addr(m0_addr), .m0_wdata(m0_wdata),
      .m0_gnt(g0_v[0]), .m0_rvalid(rv0_v[0]), .m0_rdata(rd0_v[0]),
      .m1_req(m1_req), .m1_wen(m1_wen), .m1_addr(m1_addr), .m1_wdata(m1_wdata),
      .m1_gnt(g1_v[0]), .m1_rvalid(rv1_v[0]), .m1_rdata(rd1_v[0]),
      .data_sram_en(en_v[0]), .data_sram_wen(swen_v[0]), .data_sram_addr(sa_v[0]),
      .data_sram_wdata(swd_v[0]), .data_sram_rdata(srd_v[0])
   );

   sram_arbiter_2x1 #(.FIXED_PRIO(1)) u_fx (
      .clk(clk), .reset(reset),
      .m0_req(m0_req), .m0_wen(m0_wen), .m0_addr(m0_addr), .m0_wdata(m0_wdata),
      .m0_gnt(g0_v[1]), .m0_rvalid(rv0_v[1]), .m0_rdata(rd0_v[1]),
      .m1_req(m1_req), .m1_wen(m1_wen), .m1_addr(m1_addr), .m1_wdata(m1_wdata),
      .m1_gnt(g1_v[1]), .m1_rvalid(rv1_v[1]), .m1_rdata(rd1_v[1]),
      .data_sram_en(en_v[1]), .data_sram_wen(swen_v[1]), .data_sram_addr(sa_v[1]),
      .data_sram_wdata(swd_v[1]), .data_sram_rdata(srd_v[1])
   );

   // ---------------- memory helpers ----------------
   function automatic logic [31:0] init_val(input logic [31:0] a);
      if (a == 32'h1000_0040) return 32'hDEAD_BEEF;
      return a ^ 32'h5A5A_0000;
   endfunction

   function automatic logic [31:0] merge(input logic [31:0] old_v, input logic [3:0] wen,
                                         input logic [31:0] wd);
      logic [31:0] r;
      r = old_v;
      for (int b = 0; b < 4; b++) if (wen[b]) r[8*b +: 8] = wd[8*b +: 8];
      return r;
   endfunction

   // Behavioural SRAMs driven by the DUTs.
   logic [31:0] sm0 [logic [31:0]];
   logic [31:0] sm1 [logic [31:0]];
   // Reference memories updated only from the bench's own predictions.
   logic [31:0] rm0 [logic [31:0]];
   logic [31:0] rm1 [logic [31:0]];

   always @(posedge clk) begin
      if (en_v[0]) begin
         if (swen_v[0] != 4'b0)
            sm0[sa_v[0]] = merge(sm0.exists(sa_v[0]) ? sm0[sa_v[0]] : init_val(sa_v[0]),
                                 swen_v[0], swd_v[0]);
         else
            srd_v[0] <= sm0.exists(sa_v[0]) ? sm0[sa_v[0]] : init_val(sa_v[0]);
      end
   end

   always @(posedge clk) begin
      if (en_v[1]) begin
         if (swen_v[1] != 4'b0)
            sm1[sa_v[1]] = merge(sm1.exists(sa_v[1]) ? sm1[sa_v[1]] : init_val(sa_v[1]),
                                 swen_v[1], swd_v[1]);
         else
            srd_v[1] <= sm1.exists(sa_v[1]) ? sm1[sa_v[1]] : init_val(sa_v[1]);
      end
   end

   function automatic logic [31:0] ref_rd(input int d, input logic [31:0] a);
      if (d == 0) return rm0.exists(a) ? rm0[a] : init_val(a);
      return rm1.exists(a) ? rm1[a] : init_val(a);
   endfunction

   task automatic ref_wr(input int d, input logic [31:0] a, input logic [3:0] wen,
                         input logic [31:0] wd);
      if (d == 0) rm0[a] = merge(ref_rd(0, a), wen, wd);
      else        rm1[a] = merge(ref_rd(1, a), wen, wd);
   endtask

   // ---------------- scoreboard and checking ----------------
   typedef struct {
      int          d;
      int          m;
      logic [31:0] data;
      int          cyc;
   } exp_t;

   exp_t sb[$];
   int   passed = 0;
   int   total  = 0;
   int   cyc    = 0;
   logic mprio [2];

   task automatic chk(input string tag, input int d, input logic [31:0] obs,
                      input logic [31:0] exp);
      total++;
      assert (obs === exp) passed++;
      else $error("FAIL %s dut%0d cyc%0d: observed=%h expected=%h", tag, d, cyc, obs, exp);
   endtask

   task automatic check_dut(input int d);
      logic [1:0]  eg;
      logic [3:0]  ewen;
      logic [31:0] eaddr, ewd;
      logic        ev;
      logic [31:0] edata;

      // expected grant
      eg = 2'b00;
      if (!reset) begin
         if (m0_req && m1_req) eg = (d == 1 || mprio[d] == 1'b0) ? 2'b01 : 2'b10;
         else                  eg = {m1_req, m0_req};
      end
      chk("gnt", d, {30'd0, g1_v[d], g0_v[d]}, {30'd0, eg});
      chk("sram_en", d, {31'd0, en_v[d]}, {31'd0, |eg});

      ewen = 4'b0; eaddr = 32'd0; ewd = 32'd0;
      if (eg[0])      begin ewen = m0_wen; eaddr = m0_addr; ewd = m0_wdata; end
      else if (eg[1]) begin ewen = m1_wen; eaddr = m1_addr; ewd = m1_wdata; end
      chk("sram_wen", d, {28'd0, swen_v[d]}, {28'd0, ewen});
      chk("sram_addr", d, sa_v[d], eaddr);
      chk("sram_wdata", d, swd_v[d], ewd);

      // read responses due this cycle
      for (int m = 0; m < 2; m++) begin
         ev = 1'b0; edata = 32'd0;
         foreach (sb[i]) if (sb[i].d == d && sb[i].m == m && sb[i].cyc == cyc) begin
            ev = 1'b1; edata = sb[i].data;
         end
         if (reset) begin ev = 1'b0; edata = 32'd0; end
         if (m == 0) begin
            chk("m0_rvalid", d, {31'd0, rv0_v[d]}, {31'd0, ev});
            chk("m0_rdata", d, rd0_v[d], edata);
         end else begin
            chk("m1_rvalid", d, {31'd0, rv1_v[d]}, {31'd0, ev});
            chk("m1_rdata", d, rd1_v[d], edata);
         end
      end
      for (int i = sb.size() - 1; i >= 0; i--)
         if (sb[i].d == d && sb[i].cyc <= cyc) sb.delete(i);

      // model update for the access performed this cycle
      if (reset) begin
         mprio[d] = 1'b0;
      end else if (eg != 2'b00) begin
         if (ewen == 4'b0) sb.push_back('{d, eg[1] ? 1 : 0, ref_rd(d, eaddr), cyc + 1});
         else              ref_wr(d, eaddr, ewen, ewd);
         mprio[d] = eg[0];
      end
   endtask

   task automatic step(input logic rst_i,
                       input logic r0, input logic [3:0] w0, input logic [31:0] a0, input logic [31:0] d0,
                       input logic r1, input logic [3:0] w1, input logic [31:0] a1, input logic [31:0] d1);
      reset = rst_i;
      m0_req = r0; m0_wen = w0; m0_addr = a0; m0_wdata = d0;
      m1_req = r1; m1_wen = w1; m1_addr = a1; m1_wdata = d1;
      @(negedge clk);
      check_dut(0);
      check_dut(1);
      @(posedge clk);
      #1;
      cyc++;
   endtask

   initial begin
      mprio[0] = 1'b0;
      mprio[1] = 1'b0;
      #1;
      // Reset held three cycles with both masters requesting.
      for (int i = 0; i < 3; i++)
         step(1, 1, 4'h0, 32'h100, 32'h0, 1, 4'h0, 32'h200, 32'h0);
      // Both masters read continuously for six cycles.
      for (int i = 0; i < 6; i++)
         step(0, 1, 4'h0, 32'h100 + 4*i, 32'h0, 1, 4'h0, 32'h200 + 4*i, 32'h0);
      // m0 drops: m1 granted in both arbiters.
      step(0, 0, 4'h0, 32'h0, 32'h0, 1, 4'h0, 32'h300, 32'h0);
      step(0, 0, 4'h0, 32'h0, 32'h0, 0, 4'h0, 32'h0, 32'h0);
      // m0 alone reads the preloaded word.
      step(0, 1, 4'h0, 32'h1000_0040, 32'h0, 0, 4'h0, 32'h0, 32'h0);
      step(0, 0, 4'h0, 32'h0, 32'h0, 0, 4'h0, 32'h0, 32'h0);
      // m1 partial write, then m0 reads the same word back.
      step(0, 0, 4'h0, 32'h0, 32'h0, 1, 4'b0011, 32'h40, 32'h1234_5678);
      step(0, 1, 4'h0, 32'h40, 32'h0, 0, 4'h0, 32'h0, 32'h0);
      step(0, 0, 4'h0, 32'h0, 32'h0, 0, 4'h0, 32'h0, 32'h0);
      // m0 read, then reset on the next cycle drops its response and the
      // priority: both requesting afterwards must give m0.
      step(0, 1, 4'h0, 32'h80, 32'h0, 0, 4'h0, 32'h0, 32'h0);
      step(1, 1, 4'h0, 32'h84, 32'h0, 1, 4'h0, 32'h88, 32'h0);
      step(0, 1, 4'h0, 32'h8C, 32'h0, 1, 4'h0, 32'h90, 32'h0);
      step(0, 0, 4'h0, 32'h0, 32'h0, 0, 4'h0, 32'h0, 32'h0);
      step(0, 0, 4'h0, 32'h0, 32'h0, 0, 4'h0, 32'h0, 32'h0);
      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule : tb_sram_arbiter_2x1
`default_nettype wire
